// File: rtl/ahb_lite_fir_engine.sv
// AHB-Lite FIR engine: shadow/active coefficient banks, one-tap-per-cycle MAC, saturating Q1.15 output.
// Optional build macro FIR_ROUNDING_EN: add 0x4000 before the >>15 (round half up) instead of truncating.
module ahb_lite_fir_engine #(
  parameter int NUM_TAPS    = 4,
  parameter int COUNT_LIMIT = 1000,
  parameter int CNT_W       = 10,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [15:0]       hwdata,
  output logic [15:0]       hrdata,
  output logic              hresp
);
  localparam int ACC_W = 32 + $clog2(NUM_TAPS);
  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_RESULT   = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_SAMPLE   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CONTROL  = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] A_COUNT    = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_COEF     = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_COEF_END = ADDR_W'(16 + 2*NUM_TAPS);
  localparam logic [ADDR_W-2:0] HW_COEF    = (ADDR_W-1)'(8);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic                      dp_vld_q, dp_vld_d, dp_wr_q, dp_wr_d, dp_size_q, dp_size_d;
  logic [ADDR_W-1:0]         dp_addr_q, dp_addr_d;
  logic [NUM_TAPS-1:0][15:0] coef_sh_q, coef_sh_d, coef_q, coef_d, hist_q, hist_d;
  logic [15:0]               sample_q, sample_d, result_q, result_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      flag_q, flag_d, err_q, err_d, pend_q, pend_d;

  logic [ADDR_W-1:0]       a;
  logic [TAP_W-1:0]        coef_idx;
  logic                    is_status, is_result, is_sample, is_ctrl, is_count, is_coef;
  logic                    mapped, busy, bad, wr_ok, ctrl_wr;
  logic [2:0]              ctrl_bits;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] rnd, shf;
  logic                    sat;
  logic [15:0]             sat_val;

  // Byte writes replace only the lane picked by the low address bit.
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic sz, input logic lane);
    if (sz)        return wd;
    else if (lane) return {wd[15:8], old[7:0]};
    else           return {old[15:8], wd[7:0]};
  endfunction

  always_comb begin
    a         = {dp_addr_q[ADDR_W-1:1], 1'b0};
    coef_idx  = TAP_W'(dp_addr_q[ADDR_W-1:1] - HW_COEF);
    is_status = (a == A_STATUS);
    is_result = (a == A_RESULT);
    is_sample = (a == A_SAMPLE);
    is_ctrl   = (a == A_CONTROL);
    is_count  = (a == A_COUNT);
    is_coef   = (a >= A_COEF) && (a < A_COEF_END);
    mapped    = is_status | is_result | is_sample | is_ctrl | is_count | is_coef;
    busy      = (state_q != S_IDLE);
    bad       = dp_vld_q & (!mapped
                 | (dp_wr_q & (is_status | is_result | is_count))
                 | (!dp_wr_q & is_ctrl)
                 | (dp_wr_q & is_sample & busy));
    wr_ok     = dp_vld_q & dp_wr_q & !bad;
    ctrl_wr   = wr_ok & is_ctrl;
    ctrl_bits = (dp_size_q | !dp_addr_q[0]) ? hwdata[2:0] : 3'b000;
    hresp     = bad;
    hrdata    = 16'h0000;
    if (dp_vld_q && !dp_wr_q && !bad) begin
      if (is_status)      hrdata = {13'b0, flag_q, err_q, busy};
      else if (is_result) hrdata = result_q;
      else if (is_sample) hrdata = sample_q;
      else if (is_count)  hrdata = 16'(count_q);
      else if (is_coef)   hrdata = coef_sh_q[coef_idx];
    end
  end

  always_comb begin
    prod = $signed(coef_q[tap_q]) * $signed(hist_q[tap_q]);
`ifdef FIR_ROUNDING_EN
    rnd  = acc_q + ACC_W'(32'h4000);
`else
    rnd  = acc_q;
`endif
    shf     = rnd >>> 15;
    sat     = !((&shf[ACC_W-1:15]) | ~(|shf[ACC_W-1:15]));
    sat_val = sat ? (shf[ACC_W-1] ? 16'h8000 : 16'h7FFF) : shf[15:0];
  end

  always_comb begin
    state_d   = state_q;
    dp_vld_d  = hsel && (htrans inside {2'b10, 2'b11});
    dp_wr_d   = hwrite;
    dp_size_d = hsize;
    dp_addr_d = haddr;
    coef_sh_d = coef_sh_q;
    coef_d    = coef_q;
    hist_d    = hist_q;
    sample_d  = sample_q;
    result_d  = result_q;
    acc_d     = acc_q;
    tap_d     = tap_q;
    count_d   = count_q;
    flag_d    = flag_q;
    err_d     = err_q;
    pend_d    = pend_q;

    if (wr_ok & is_sample) sample_d = merge(sample_q, hwdata, dp_size_q, dp_addr_q[0]);
    if (wr_ok & is_coef)
      coef_sh_d[coef_idx] = merge(coef_sh_q[coef_idx], hwdata, dp_size_q, dp_addr_q[0]);
    // Clears come first so a same-cycle set from DONE overrides them.
    if (ctrl_wr & ctrl_bits[1]) flag_d = 1'b0;
    if (ctrl_wr & ctrl_bits[2]) err_d  = 1'b0;

    if (state_q == S_IDLE) begin
      if (pend_q | (ctrl_wr & ctrl_bits[0])) coef_d = coef_sh_q;
      pend_d = 1'b0;
    end else if (ctrl_wr & ctrl_bits[0]) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (wr_ok & is_sample) state_d = S_LOAD;
      S_LOAD: begin
        hist_d  = {hist_q[NUM_TAPS-2:0], sample_q};
        acc_d   = '0;
        tap_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-32){prod[31]}}, prod};
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_W'(NUM_TAPS-1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = sat_val;
        if (sat) err_d = 1'b1;
        if (count_q == CNT_W'(COUNT_LIMIT-1)) begin
          count_d = '0;
          flag_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dp_vld_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_size_q <= 1'b0;
      dp_addr_q <= '0;
      coef_sh_q <= '0;
      coef_q    <= '0;
      hist_q    <= '0;
      sample_q  <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      tap_q     <= '0;
      count_q   <= '0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dp_vld_q  <= dp_vld_d;
      dp_wr_q   <= dp_wr_d;
      dp_size_q <= dp_size_d;
      dp_addr_q <= dp_addr_d;
      coef_sh_q <= coef_sh_d;
      coef_q    <= coef_d;
      hist_q    <= hist_d;
      sample_q  <= sample_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      tap_q     <= tap_d;
      count_q   <= count_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end
endmodule

// File: doc/ahb_lite_fir_engine.md
# ahb_lite_fir_engine

Parametrised AHB-Lite FIR filter engine. It is the next-generation filter slave: the tap count, the sample-counter limit and the accumulator sizing are all configurable. It has shadow coefficient registers with an atomic commit, a sequential multiply-accumulate (MAC) datapath, and signed saturating output. It sits on the AHB-Lite bus as a single slave; software writes coefficients and samples, then polls status and reads results.

## Interface
- NUM_TAPS, 4: filter taps, legal range 2..16.
- COUNT_LIMIT, 1000: number of processed samples at which count_flag sets.
- CNT_W, 10: sample-counter width; must satisfy 2^CNT_W ≥ COUNT_LIMIT.
- ADDR_W, 6: haddr width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  byte address.
- hsize  in  1  0 = byte, 1 = halfword.
- htrans  in  2  IDLE = 0, NONSEQ = 2; SEQ is treated as NONSEQ; BUSY is ignored.
- hwrite  in  1  1 = write.
- hwdata  in  16  write data, sampled in the data phase.
- hrdata  out  16  read data, driven in the data phase.
- hresp  out  1  error response.

## Operation
- Register map (halfword-aligned):
  - 0x00 STATUS (RO): [0] busy, [1] err, [2] count_flag.
  - 0x02 RESULT (RO).
  - 0x04 SAMPLE (RW).
  - 0x06 CONTROL (WO): writing 1 to a bit triggers its action.
    - [0] commit.
    - [1] clear count_flag.
    - [2] clear err.
  - 0x08 COUNT (RO).
  - 0x10+2k: COEF[k] shadow (RW), k < NUM_TAPS.
- hresp=1 in the data phase, with no state change, for:
  - an unmapped address;
  - a write to an RO register;
  - a read of CONTROL;
  - a SAMPLE write while busy (the sample is dropped).
- Byte access: haddr[0] selects the lane (0 = [7:0], 1 = [15:8]). Writes touch only that lane; reads return the full halfword.
- Commit: copies all shadow coefficients into the active coefficients in one cycle when the FSM is in IDLE. A commit issued while busy is held pending and applied on the first IDLE cycle.
- Data formats:
  - Samples are signed 16-bit.
  - Coefficients are signed Q1.15.
  - Products are 32-bit signed.
  - The accumulator is 32+clog2(NUM_TAPS) bits signed.
- Result computation:
  - y = sum over k of COEF[k]·x[n−k].
  - Shift right by 15, then saturate to [0x8000, 0x7FFF].
  - Saturation sets err (sticky).
- Sample history is NUM_TAPS deep and resets to 0.
- FSM states:
  - IDLE → LOAD on an accepted SAMPLE write (data phase).
  - LOAD: shift the sample into the history; clear the accumulator.
  - MAC: one tap per cycle for NUM_TAPS cycles.
  - DONE: write RESULT; COUNT+1. If COUNT reaches COUNT_LIMIT, COUNT→0 and count_flag=1 (sticky). Then → IDLE.
- busy=1 in LOAD, MAC and DONE.
- Simultaneous events:
  - A clear of count_flag in the same cycle as it sets: the set wins.
  - A clear of err in the same cycle as a saturation: the set wins.
- rst at any point, including mid-MAC, aborts the computation. After rst:
  - all registers, history, COUNT and pending commit are 0;
  - FSM is in IDLE;
  - hrdata=0, hresp=0.

## Timing
- Address phase in cycle A is registered; the data phase is in cycle A+1. hrdata and hresp are valid in A+1 (combinational from the registered address).
- SAMPLE write data phase in cycle N:
  - LOAD in N+1.
  - MAC in N+2..N+1+NUM_TAPS.
  - DONE in N+2+NUM_TAPS.
  - From N+3+NUM_TAPS: RESULT holds the new value and busy=0.
- Back-to-back transfers are supported with zero wait states. hready is not modelled; the slave is always ready.
- A read of STATUS in the same cycle as a state change returns the pre-edge value.

## Configuration
- FIR_ROUNDING_EN defined: 0x4000 is added to the accumulator before the >>15 (round half up).
- FIR_ROUNDING_EN undefined: truncation.
- Example: COEF=0x0001, sample=0x4000 gives RESULT 0x0001 with the macro and 0x0000 without it.

## Test plan
- Reset: assert rst for 2 cycles. STATUS, RESULT and COUNT read 0x0000, and hresp=0 on every read.
- Basic filter (NUM_TAPS=4): set COEF[0..3]=0x4000, commit, then write samples 100, 200, 300, 400. RESULT reads 50, 150, 300, 500 in turn, and COUNT=4.
- Saturation: set all COEF=0x7FFF, commit, write 0x7FFF twice. RESULT is 0x7FFE then 0x7FFF, err=1; err clears after writing 0x0004 to CONTROL.
- Busy protocol: write a SAMPLE, then write 0x1234 to SAMPLE at N+2. hresp=1 for the second write, RESULT is unaffected by 0x1234, and busy falls at N+7. A commit issued at N+3 takes effect at N+7.
- Bus errors: each of the following gives hresp=1 and no register change:
  - write to 0x02;
  - access to 0x0A;
  - read of 0x06.

  Separately, a byte write of 0xAB to 0x11 sets COEF[0][15:8]=0xAB with [7:0] unchanged.
- Counter (COUNT_LIMIT=3): process 3 samples. count_flag=1 and COUNT=0; writing 0x0002 to CONTROL clears the flag.
